// File: rtl/sha256_stream_ctrl_if.sv
// Stream, core and digest signals between sha256_stream_ctrl and its neighbours.
// slave is the controller's view; master is the source/core/consumer side.
interface sha256_stream_ctrl_if;
  logic         msg_valid;
  logic         msg_ready;
  logic [31:0]  msg_data;
  logic         msg_last;
  logic [1:0]   msg_bytes;
  logic         core_start;
  logic [511:0] core_block;
  logic         core_last_block;
  logic         core_done;
  logic [255:0] core_digest;
  logic         digest_valid;
  logic         digest_ready;
  logic [255:0] digest;
  logic         busy;

  modport slave (
    input  msg_valid, msg_data, msg_last, msg_bytes, core_done, core_digest, digest_ready,
    output msg_ready, core_start, core_block, core_last_block, digest_valid, digest, busy
  );

  modport master (
    output msg_valid, msg_data, msg_last, msg_bytes, core_done, core_digest, digest_ready,
    input  msg_ready, core_start, core_block, core_last_block, digest_valid, digest, busy
  );
endinterface

// File: rtl/sha256_stream_ctrl.sv
// Assembles a big-endian word stream into padded 512-bit blocks, sequences sha256_core
// block by block and hands the final digest out on a valid/ready port.
module sha256_stream_ctrl #(
  parameter int unsigned LEN_W = 64
) (
  input  logic               iClk,
  input  logic               iReset_n,
  sha256_stream_ctrl_if.slave bus
);

  typedef enum logic [2:0] {StFill, StPad, StStart, StWait, StExtra, StOut} state_e;

  state_e             state_q;
  logic [31:0]        blk_q [16];
  logic [3:0]         idx_q;
  logic [2:0]         last_n_q;
  logic [LEN_W-1:0]   byte_cnt_q;
  logic               pend_last_q;
  logic               extra_q;
  logic               pad_pending_q;
  logic               core_start_q;
  logic               core_last_q;
  logic               digest_valid_q;
  logic               busy_q;
  logic [255:0]       digest_q;

  logic               msg_ready;
  logic [2:0]         n_bytes;
  logic [31:0]        msg_masked;
  logic [31:0]        pad_mark;
  logic [63:0]        bit_len;
  logic [6:0]         used;
  logic               pad_pending_now;
  logic               fits;

  assign msg_ready = iReset_n && (state_q == StFill);

  always_comb begin
    n_bytes = (bus.msg_last && (bus.msg_bytes != 2'd0)) ? {1'b0, bus.msg_bytes} : 3'd4;
    case (n_bytes)
      3'd1:    msg_masked = bus.msg_data & 32'hFF00_0000;
      3'd2:    msg_masked = bus.msg_data & 32'hFFFF_0000;
      3'd3:    msg_masked = bus.msg_data & 32'hFFFF_FF00;
      default: msg_masked = bus.msg_data;
    endcase
    case (last_n_q)
      3'd1:    pad_mark = 32'h0080_0000;
      3'd2:    pad_mark = 32'h0000_8000;
      3'd3:    pad_mark = 32'h0000_0080;
      default: pad_mark = 32'h0000_0000;
    endcase
    bit_len         = 64'(byte_cnt_q) << 3;
    used            = {1'b0, idx_q, 2'b00} + {4'b0000, last_n_q} + 7'd1;
    // A full last word in slot 15 leaves no room for the 0x80 marker in this block.
    pad_pending_now = (last_n_q == 3'd4) && (idx_q == 4'd15);
    fits            = (used <= 7'd56) && !pad_pending_now;
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q        <= StFill;
      for (int i = 0; i < 16; i++) blk_q[i] <= '0;
      idx_q          <= '0;
      last_n_q       <= '0;
      byte_cnt_q     <= '0;
      pend_last_q    <= 1'b0;
      extra_q        <= 1'b0;
      pad_pending_q  <= 1'b0;
      core_start_q   <= 1'b0;
      core_last_q    <= 1'b0;
      digest_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      digest_q       <= '0;
    end else begin
      core_start_q <= 1'b0;
      case (state_q)
        StFill: begin
          if (bus.msg_valid && msg_ready) begin
            blk_q[idx_q] <= msg_masked;
            byte_cnt_q   <= byte_cnt_q + LEN_W'(n_bytes);
            busy_q       <= 1'b1;
            if (bus.msg_last) begin
              last_n_q <= n_bytes;
              state_q  <= StPad;
            end else if (idx_q == 4'd15) begin
              pend_last_q  <= 1'b0;
              extra_q      <= 1'b0;
              core_start_q <= 1'b1;
              core_last_q  <= 1'b0;
              state_q      <= StStart;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end
        end
        StPad: begin
          if (last_n_q != 3'd4) begin
            blk_q[idx_q] <= blk_q[idx_q] | pad_mark;
          end else if (idx_q != 4'd15) begin
            blk_q[idx_q + 4'd1] <= 32'h8000_0000;
          end
          pad_pending_q <= pad_pending_now;
          if (fits) begin
            blk_q[14]   <= bit_len[63:32];
            blk_q[15]   <= bit_len[31:0];
            pend_last_q <= 1'b1;
            extra_q     <= 1'b0;
            core_last_q <= 1'b1;
          end else begin
            pend_last_q <= 1'b0;
            extra_q     <= 1'b1;
            core_last_q <= 1'b0;
          end
          core_start_q <= 1'b1;
          state_q      <= StStart;
        end
        StStart: state_q <= StWait;
        StWait: begin
          if (bus.core_done) begin
            for (int i = 0; i < 16; i++) blk_q[i] <= '0;
            idx_q       <= '0;
            core_last_q <= 1'b0;
            if (pend_last_q) begin
              digest_q       <= bus.core_digest;
              digest_valid_q <= 1'b1;
              state_q        <= StOut;
            end else if (extra_q) begin
              state_q <= StExtra;
            end else begin
              state_q <= StFill;
            end
          end
        end
        StExtra: begin
          blk_q[0]      <= pad_pending_q ? 32'h8000_0000 : 32'h0000_0000;
          blk_q[14]     <= bit_len[63:32];
          blk_q[15]     <= bit_len[31:0];
          pend_last_q   <= 1'b1;
          extra_q       <= 1'b0;
          pad_pending_q <= 1'b0;
          core_start_q  <= 1'b1;
          core_last_q   <= 1'b1;
          state_q       <= StStart;
        end
        StOut: begin
          if (bus.digest_ready) begin
            digest_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            byte_cnt_q     <= '0;
            state_q        <= StFill;
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_block
    assign bus.core_block[511-32*i -: 32] = blk_q[i];
  end

  assign bus.msg_ready       = msg_ready;
  assign bus.core_start      = core_start_q;
  assign bus.core_last_block = core_last_q;
  assign bus.digest_valid    = digest_valid_q;
  assign bus.digest          = digest_q;
  assign bus.busy            = busy_q;

endmodule

// File: tb/tb_sha256_stream_ctrl.sv
// Directed bench for sha256_stream_ctrl; a reference SHA-256 compression stands in for the core.
module tb_sha256_stream_ctrl;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] DigAbc =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] Dig56 =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [511:0] Blk64 = 512'h01020304_05060708_090a0b0c_0d0e0f10_11121314_15161718_191a1b1c_1d1e1f20_21222324_25262728_292a2b2c_2d2e2f30_31323334_35363738_393a3b3c_3d3e3f40;
  localparam logic [511:0] Pad64 = {32'h8000_0000, 448'h0, 32'h0000_0200};
  localparam logic [511:0] Blk55 = {440'h01020304_05060708_090a0b0c_0d0e0f10_11121314_15161718_191a1b1c_1d1e1f20_21222324_25262728_292a2b2c_2d2e2f30_31323334_353637, 8'h80, 64'h1b8};

  logic clk;
  logic rst_n;

  sha256_stream_ctrl_if bus ();

  sha256_stream_ctrl #(.LEN_W(64)) dut (
    .iClk    (clk),
    .iReset_n(rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_checks;
  int           n_pass;
  logic [7:0]   msg_b [64];
  int           msg_len;
  logic [511:0] cap_blks [$];
  logic         cap_lbs [$];
  logic [511:0] cap_blk;
  logic         cap_lb;
  logic [255:0] h_run;
  bit           core_mute;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = w[t-16] + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-7]
           + (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10));
    {a, b, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + hin[255:224], b + hin[223:192], c + hin[191:160], d + hin[159:128],
            e + hin[127:96], f + hin[95:64], g + hin[63:32], h + hin[31:0]};
  endfunction

  // Core stand-in: hashes each started block and answers a few cycles later.
  initial begin
    bus.core_done   = 1'b0;
    bus.core_digest = '0;
    h_run           = IV;
    forever begin
      @(negedge clk);
      if (bus.core_start === 1'b1) begin
        cap_blk = bus.core_block;
        cap_lb  = bus.core_last_block;
        cap_blks.push_back(cap_blk);
        cap_lbs.push_back(cap_lb);
        @(negedge clk);
        check("start_pulse", 512'(bus.core_start), 512'(0));
        if (!core_mute) begin
          h_run = compress(h_run, cap_blk);
          repeat (3) @(negedge clk);
          check("blk_hold", bus.core_block, cap_blk);
          check("lb_hold", 512'(bus.core_last_block), 512'(cap_lb));
          bus.core_digest = h_run;
          bus.core_done   = 1'b1;
          @(negedge clk);
          bus.core_done = 1'b0;
          if (cap_lb) begin
            check("dv_latency", 512'(bus.digest_valid), 512'(1));
            h_run = IV;
          end
        end
      end
    end
  end

  task automatic load_str(input string s);
    msg_len = s.len();
    for (int i = 0; i < msg_len; i++) msg_b[i] = s[i];
  endtask

  task automatic load_seq(input int len);
    msg_len = len;
    for (int i = 0; i < len; i++) msg_b[i] = 8'(i + 1);
  endtask

  task automatic send_msg(input int gap_mod);
    int          nw;
    int          t;
    logic [31:0] d;
    nw = (msg_len + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      d = '0;
      for (int j = 0; j < 4; j++)
        if (4 * w + j < msg_len) d[31-8*j -: 8] = msg_b[4*w+j];
      bus.msg_data  = d;
      bus.msg_last  = (w == nw - 1);
      bus.msg_bytes = (w == nw - 1) ? 2'(msg_len % 4) : 2'd0;
      bus.msg_valid = 1'b1;
      t = 0;
      while (bus.msg_ready !== 1'b1 && t < 500) begin
        @(negedge clk);
        t++;
      end
      if (t >= 500) check("ready_timeout", 512'(bus.msg_ready), 512'(1));
      @(negedge clk);
      bus.msg_valid = 1'b0;
      if (gap_mod > 0) repeat (w % gap_mod) @(negedge clk);
    end
    bus.msg_last = 1'b0;
  endtask

  task automatic wait_digest(input logic [255:0] exp, input int hold, input bit probe);
    int t;
    t = 0;
    while (bus.digest_valid !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("digest_valid", 512'(bus.digest_valid), 512'(1));
    check("digest", 512'(bus.digest), 512'(exp));
    if (probe) begin
      bus.msg_data  = 32'hdead_beef;
      bus.msg_last  = 1'b1;
      bus.msg_bytes = 2'd0;
      bus.msg_valid = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 512'(bus.digest_valid), 512'(1));
      check("hold_digest", 512'(bus.digest), 512'(exp));
      check("hold_ready", 512'(bus.msg_ready), 512'(0));
    end
    bus.msg_valid    = 1'b0;
    bus.msg_last     = 1'b0;
    bus.digest_ready = 1'b1;
    @(negedge clk);
    bus.digest_ready = 1'b0;
    check("dv_drop", 512'(bus.digest_valid), 512'(0));
    check("busy_drop", 512'(bus.busy), 512'(0));
    check("ready_back", 512'(bus.msg_ready), 512'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    n_checks = 0;
    n_pass   = 0;
    core_mute = 1'b0;
    rst_n = 1'b0;
    bus.msg_valid    = 1'b0;
    bus.msg_data     = '0;
    bus.msg_last     = 1'b0;
    bus.msg_bytes    = '0;
    bus.digest_ready = 1'b0;
    #1;
    check("rst_ready", 512'(bus.msg_ready), 512'(0));
    check("rst_start", 512'(bus.core_start), 512'(0));
    check("rst_lb", 512'(bus.core_last_block), 512'(0));
    check("rst_dv", 512'(bus.digest_valid), 512'(0));
    check("rst_digest", 512'(bus.digest), 512'(0));
    check("rst_busy", 512'(bus.busy), 512'(0));
    check("rst_block", bus.core_block, 512'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 512'(bus.msg_ready), 512'(1));

    // "abc": single padded block
    load_str("abc");
    send_msg(0);
    check("abc_busy", 512'(bus.busy), 512'(1));
    @(negedge clk);
    check("abc_start_lat", 512'(bus.core_start), 512'(1));
    wait_digest(DigAbc, 0, 1'b0);
    check("abc_nblk", 512'(cap_blks.size()), 512'(1));
    check("abc_w0", 512'(cap_blks[0][511:480]), 512'(32'h6162_6380));
    check("abc_mid", 512'(cap_blks[0][479:32]), 512'(0));
    check("abc_w15", 512'(cap_blks[0][31:0]), 512'(32'h18));
    check("abc_lb", 512'(cap_lbs[0]), 512'(1));
    cap_blks.delete();
    cap_lbs.delete();

    // 56 bytes: marker fits, length does not -> extra block
    load_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    send_msg(0);
    wait_digest(Dig56, 0, 1'b0);
    check("m56_nblk", 512'(cap_blks.size()), 512'(2));
    check("m56_lb0", 512'(cap_lbs[0]), 512'(0));
    check("m56_lb1", 512'(cap_lbs[1]), 512'(1));
    check("m56_b0w0", 512'(cap_blks[0][511:480]), 512'(32'h6162_6364));
    check("m56_b0w14", 512'(cap_blks[0][63:32]), 512'(32'h8000_0000));
    check("m56_b0w15", 512'(cap_blks[0][31:0]), 512'(0));
    check("m56_b1", cap_blks[1], {480'h0, 32'h0000_01c0});
    cap_blks.delete();
    cap_lbs.delete();

    // 64 bytes: data block untouched, marker goes to word 0 of the extra block
    load_seq(64);
    send_msg(0);
    wait_digest(compress(compress(IV, Blk64), Pad64), 0, 1'b0);
    check("m64_nblk", 512'(cap_blks.size()), 512'(2));
    check("m64_b0", cap_blks[0], Blk64);
    check("m64_b1", cap_blks[1], Pad64);
    check("m64_lb0", 512'(cap_lbs[0]), 512'(0));
    check("m64_lb1", 512'(cap_lbs[1]), 512'(1));
    cap_blks.delete();
    cap_lbs.delete();

    // 55 bytes with source gaps and a stalled digest consumer
    load_seq(55);
    send_msg(3);
    wait_digest(compress(IV, Blk55), 20, 1'b1);
    check("m55_nblk", 512'(cap_blks.size()), 512'(1));
    check("m55_w13", 512'(cap_blks[0][95:64]), 512'(32'h3536_3780));
    check("m55_w15", 512'(cap_blks[0][31:0]), 512'(32'h0000_01b8));
    check("m55_blk", cap_blks[0], Blk55);
    check("m55_lb", 512'(cap_lbs[0]), 512'(1));
    cap_blks.delete();
    cap_lbs.delete();

    // Reset while waiting on the first block of a two-block message
    core_mute = 1'b1;
    load_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    send_msg(0);
    t = 0;
    while (cap_blks.size() == 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("mid_started", 512'(cap_blks.size()), 512'(1));
    repeat (2) @(negedge clk);
    check("mid_busy", 512'(bus.busy), 512'(1));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 512'(bus.msg_ready), 512'(0));
    check("mid_rst_start", 512'(bus.core_start), 512'(0));
    check("mid_rst_lb", 512'(bus.core_last_block), 512'(0));
    check("mid_rst_dv", 512'(bus.digest_valid), 512'(0));
    check("mid_rst_digest", 512'(bus.digest), 512'(0));
    check("mid_rst_busy", 512'(bus.busy), 512'(0));
    check("mid_rst_block", bus.core_block, 512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    core_mute = 1'b0;
    h_run = IV;
    cap_blks.delete();
    cap_lbs.delete();
    @(negedge clk);
    load_str("abc");
    send_msg(0);
    wait_digest(DigAbc, 0, 1'b0);
    check("post_rst_nblk", 512'(cap_blks.size()), 512'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
